// File: rtl/const_load_sequencer_pkg.sv
// rtl/const_load_sequencer_pkg.sv - shared state encoding and defaults for the constant-load sequencer
package const_load_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LUI  = 2'd1,
    ST_ORI  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/const_load_sequencer_forlui_16to32.sv
// rtl/const_load_sequencer_forlui_16to32.sv - LUI word former: upper half from immediate, lower half zero
module forlui_16to32 (
  input  logic [15:0] i_imm16,
  output logic [31:0] o_word
);

  assign o_word = {i_imm16, 16'h0000};

endmodule

// File: rtl/const_load_sequencer.sv
// rtl/const_load_sequencer.sv - expands a 32-bit constant load into LUI/ORI register-file writes
module const_load_sequencer
  import const_load_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter bit ELIDE_EN   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [REG_ADDR_W-1:0] i_req_rd,
  input  logic [31:0]           i_req_imm,
  input  logic                  i_rf_grant,
  output logic                  o_rf_req,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_waddr,
  output logic [31:0]           o_rf_wdata,
  output logic                  o_busy,
  output logic                  o_done
);

  state_t                r_state;
  state_t                w_next;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [15:0]           r_hi;
  logic [15:0]           r_lo;
  logic [31:0]           w_lui;
  logic                  w_accept;

  forlui_16to32 u_forlui (
    .i_imm16 (r_hi),
    .o_word  (w_lui)
  );

  assign w_accept = i_req_valid && (r_state == ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_rd    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rd <= i_req_rd;
        r_hi <= i_req_imm[31:16];
        r_lo <= i_req_imm[15:0];
      end
    end
  end

  // $zero destinations skip the RF entirely; elision only drops a step whose half is zero
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (i_req_rd == '0)                              w_next = ST_DONE;
          else if (ELIDE_EN && (i_req_imm[31:16] == 16'h0)) w_next = ST_ORI;
          else                                             w_next = ST_LUI;
        end
      end
      ST_LUI: begin
        if (i_rf_grant) begin
          if (ELIDE_EN && (r_lo == 16'h0)) w_next = ST_DONE;
          else                             w_next = ST_ORI;
        end
      end
      ST_ORI: begin
        if (i_rf_grant) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_rf_req    = (r_state == ST_LUI) || (r_state == ST_ORI);
  assign o_rf_we     = o_rf_req && i_rf_grant;
  assign o_rf_waddr  = r_rd;
  assign o_rf_wdata  = (r_state == ST_ORI) ? (w_lui | {16'h0000, r_lo}) : w_lui;

endmodule

// File: tb/tb_const_load_sequencer.sv
// tb/tb_const_load_sequencer.sv - self-checking bench: vector table, corner sequences, randomized model compare
module tb_const_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic        grant;
  logic [4:0]  rdv;
  logic [31:0] immv;

  logic        rdy_e, req_e, we_e, busy_e, done_e;
  logic [4:0]  wa_e;
  logic [31:0] wd_e;
  logic        rdy_n, req_n, we_n, busy_n, done_n;
  logic [4:0]  wa_n;
  logic [31:0] wd_n;

  const_load_sequencer #(.REG_ADDR_W(5), .ELIDE_EN(1'b1)) dut_e (
    .i_clk(clk), .i_reset(rst), .i_req_valid(vld), .o_req_ready(rdy_e),
    .i_req_rd(rdv), .i_req_imm(immv), .i_rf_grant(grant), .o_rf_req(req_e),
    .o_rf_we(we_e), .o_rf_waddr(wa_e), .o_rf_wdata(wd_e), .o_busy(busy_e), .o_done(done_e)
  );

  const_load_sequencer #(.REG_ADDR_W(5), .ELIDE_EN(1'b0)) dut_n (
    .i_clk(clk), .i_reset(rst), .i_req_valid(vld), .o_req_ready(rdy_n),
    .i_req_rd(rdv), .i_req_imm(immv), .i_rf_grant(grant), .o_rf_req(req_n),
    .o_rf_we(we_n), .o_rf_waddr(wa_n), .o_rf_wdata(wd_n), .o_busy(busy_n), .o_done(done_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [36:0] q_e[$];
  logic [36:0] q_n[$];
  int          dc_e, dc_n;
  int          dn_e = 0;
  int          dn_n = 0;
  logic        hold_e, hold_n, rand_grant;
  logic [36:0] held_e, held_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // While a write is pending without grant, request and address/data must not move
  always @(negedge clk) begin
    if (rst) begin
      hold_e = 1'b0;
      hold_n = 1'b0;
    end else begin
      if (hold_e) chk("hold_e", {req_e, wa_e, wd_e}, {1'b1, held_e});
      if (hold_n) chk("hold_n", {req_n, wa_n, wd_n}, {1'b1, held_n});
      if (we_e) q_e.push_back({wa_e, wd_e});
      if (we_n) q_n.push_back({wa_n, wd_n});
      if (done_e) begin dc_e = cyc; dn_e++; end
      if (done_n) begin dc_n = cyc; dn_n++; end
      hold_e = req_e && !we_e;
      held_e = {wa_e, wd_e};
      hold_n = req_n && !we_n;
      held_n = {wa_n, wd_n};
    end
  end

  always @(posedge clk) begin
    if (rand_grant) begin
      #1;
      grant = ($urandom_range(3) != 0);
    end
  end

  function automatic int model(input logic [4:0] rd, input logic [31:0] imm, input bit elide,
                               output logic [36:0] w0, output logic [36:0] w1);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = imm[31:16];
    lo = imm[15:0];
    w0 = '0;
    w1 = '0;
    if (rd == 5'd0) return 0;
    if (!elide || (hi != 16'h0 && lo != 16'h0)) begin
      w0 = {rd, hi, 16'h0000};
      w1 = {rd, imm};
      return 2;
    end
    w0 = {rd, imm};
    return 1;
  endfunction

  task automatic cmp_q(input string nm, input logic [36:0] q[$], input int n,
                       input logic [36:0] w0, input logic [36:0] w1);
    chk({nm, "_count"}, 64'(q.size()), 64'(n));
    if (n >= 1 && q.size() >= 1) chk({nm, "_w0"}, 64'(q[0]), 64'(w0));
    if (n >= 2 && q.size() >= 2) chk({nm, "_w1"}, 64'(q[1]), 64'(w1));
  endtask

  task automatic do_req(input logic [4:0] rd, input logic [31:0] imm, output int lat_e, output int lat_n);
    int a;
    q_e.delete();
    q_n.delete();
    dc_e = -1;
    dc_n = -1;
    @(posedge clk); #1;
    vld = 1'b1; rdv = rd; immv = imm;
    @(negedge clk);
    chk("ready_before_accept", {rdy_e, rdy_n}, 2'b11);
    @(posedge clk); #1;
    a = cyc;
    vld = 1'b0;
    for (int k = 0; k < 300 && (dc_e < 0 || dc_n < 0); k++) @(posedge clk);
    chk("done_seen", {dc_e >= 0, dc_n >= 0}, 2'b11);
    lat_e = dc_e - a + 1;
    lat_n = dc_n - a + 1;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] imm;
    int          n_e;
    logic [31:0] e_last;
    int          lat_e;
    int          lat_n;
    logic [31:0] n_first;
  } vec_t;

  initial begin
    vec_t        vecs[5];
    int          le, ln, dn0, ne, nn;
    logic [36:0] e0, e1, n0, n1;
    logic [4:0]  r;
    logic [31:0] im;

    vecs[0] = '{5'd8,  32'h1234_5678, 2, 32'h1234_5678, 3, 3, 32'h1234_0000};
    vecs[1] = '{5'd3,  32'h0000_00FF, 1, 32'h0000_00FF, 2, 3, 32'h0000_0000};
    vecs[2] = '{5'd31, 32'hFFFF_0000, 1, 32'hFFFF_0000, 2, 3, 32'hFFFF_0000};
    vecs[3] = '{5'd0,  32'hDEAD_BEEF, 0, 32'h0000_0000, 1, 1, 32'h0000_0000};
    vecs[4] = '{5'd7,  32'h0000_0000, 1, 32'h0000_0000, 2, 3, 32'h0000_0000};

    rst = 1'b1; vld = 1'b0; grant = 1'b1; rand_grant = 1'b0; rdv = '0; immv = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_e", {rdy_e, req_e, we_e, busy_e, done_e, wa_e, wd_e}, {1'b1, 4'b0, 5'd0, 32'd0});
    chk("reset_n", {rdy_n, req_n, we_n, busy_n, done_n, wa_n, wd_n}, {1'b1, 4'b0, 5'd0, 32'd0});

    for (int i = 0; i < 5; i++) begin
      do_req(vecs[i].rd, vecs[i].imm, le, ln);
      chk("tbl_lat_e", 64'(le), 64'(vecs[i].lat_e));
      chk("tbl_lat_n", 64'(ln), 64'(vecs[i].lat_n));
      chk("tbl_cnt_e", 64'(q_e.size()), 64'(vecs[i].n_e));
      if (vecs[i].n_e > 0 && q_e.size() > 0)
        chk("tbl_last_e", 64'(q_e[q_e.size()-1]), 64'({vecs[i].rd, vecs[i].e_last}));
      if (vecs[i].n_e == 2 && q_e.size() == 2)
        chk("tbl_first_e", 64'(q_e[0]), 64'({vecs[i].rd, vecs[i].n_first}));
      chk("tbl_cnt_n", 64'(q_n.size()), (vecs[i].rd != 0) ? 64'd2 : 64'd0);
      if (vecs[i].rd != 0 && q_n.size() == 2) begin
        chk("tbl_first_n", 64'(q_n[0]), 64'({vecs[i].rd, vecs[i].n_first}));
        chk("tbl_second_n", 64'(q_n[1]), 64'({vecs[i].rd, vecs[i].imm}));
      end
    end

    // $zero destination with a second request held during the busy cycle
    dn0 = dn_e;
    q_e.delete(); q_n.delete();
    @(posedge clk); #1;
    vld = 1'b1; rdv = 5'd0; immv = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rdv = 5'd9; immv = 32'h1234_5678;
    @(negedge clk);
    chk("zero_busy", {busy_e, rdy_e, done_e, req_e}, 4'b1010);
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("zero_no_writes", 64'(q_e.size() + q_n.size()), 64'd0);
    chk("zero_one_done", 64'(dn_e - dn0), 64'd1);
    chk("zero_idle", {busy_e, busy_n}, 2'b00);

    // grant withheld 4 cycles in LUI and 2 in ORI
    q_e.delete(); q_n.delete();
    @(posedge clk); #1;
    grant = 1'b0; vld = 1'b1; rdv = 5'd5; immv = 32'hF0F0_F0F0;
    @(posedge clk); #1;
    vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_lui", {req_e, we_e, wa_e, wd_e}, {2'b10, 5'd5, 32'hF0F0_0000});
      @(posedge clk); #1;
    end
    grant = 1'b1;
    @(negedge clk);
    chk("lui_we", {we_e, we_n}, 2'b11);
    @(posedge clk); #1;
    grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_ori", {req_e, we_e, wa_e, wd_e}, {2'b10, 5'd5, 32'hF0F0_F0F0});
      @(posedge clk); #1;
    end
    grant = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_done", {done_e, done_n}, 2'b11);
    chk("stall_writes_e", 64'(q_e.size()), 64'd2);
    chk("stall_writes_n", 64'(q_n.size()), 64'd2);
    if (q_e.size() == 2) chk("stall_ori_data", 64'(q_e[1]), 64'({5'd5, 32'hF0F0_F0F0}));

    // reset while waiting in ORI
    q_e.delete(); q_n.delete();
    @(posedge clk); #1;
    grant = 1'b1; vld = 1'b1; rdv = 5'd8; immv = 32'h1234_5678;
    @(posedge clk); #1;
    vld = 1'b0;
    @(posedge clk); #1;
    grant = 1'b0;
    @(negedge clk);
    chk("in_ori", {req_e, wd_e}, {1'b1, 32'h1234_5678});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state", {rdy_e, req_e, we_e, done_e, busy_e}, 5'b10000);
    grant = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_writes", 64'(q_e.size()), 64'd1);

    rand_grant = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r  = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom);
      im[31:16] = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      im[15:0]  = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      do_req(r, im, le, ln);
      ne = model(r, im, 1'b1, e0, e1);
      nn = model(r, im, 1'b0, n0, n1);
      cmp_q("rand_e", q_e, ne, e0, e1);
      cmp_q("rand_n", q_n, nn, n0, n1);
    end
    rand_grant = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
